// File: rtl/dcd_axil_sink_regs_pkg.sv
// dcd_axil_sink_regs_pkg: response codes and FSM state types shared by the sink register bank
package dcd_axil_pkg;
  typedef enum logic [1:0] {RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10} resp_t;
  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_RESP} rd_state_t;
endpackage

// File: rtl/dcd_axil_sink_regs_if.sv
// dcd_axil_sink_regs_if: AXI4-Lite bus between the dcd master and the sink register bank
interface dcd_axil_sink_regs_if #(parameter int ADDR_W = 6);
  logic [ADDR_W-1:0] awaddr;
  logic [2:0] awprot;
  logic awvalid, awready;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic wvalid, wready;
  logic [1:0] bresp;
  logic bvalid, bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0] arprot;
  logic arvalid, arready;
  logic [31:0] rdata;
  logic [1:0] rresp;
  logic rvalid, rready;
  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    input awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/dcd_axil_sink_regs_regfile.sv
// dcd_axil_regfile: word storage with async clear, byte-enable write and registered read
module dcd_axil_regfile #(
  parameter int NUM_REGS = 16,
  parameter int IW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [IW-1:0] widx_i,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    wstrb_i,
  input  logic          re_i,
  input  logic          rok_i,
  input  logic [IW-1:0] ridx_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [NUM_REGS];
  logic [31:0] rdata_q;
  // byte-lane writes; only enabled lanes change
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      for (int b = 0; b < 4; b++) if (wstrb_i[b]) mem_q[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  // read samples pre-write contents, so a same-edge write is not visible
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata_q <= '0;
    else if (re_i) rdata_q <= rok_i ? mem_q[ridx_i] : '0;
  assign rdata_o = rdata_q;
endmodule

// File: rtl/dcd_axil_sink_regs.sv
// dcd_axil_sink_regs: AXI4-Lite slave register bank with independent write/read FSMs and write counter
module dcd_axil_sink_regs
  import dcd_axil_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int NUM_REGS = 16
) (
  input  logic ACLK,
  input  logic ARESETN,
  dcd_axil_sink_regs_if.slave s,
  output logic [15:0] WR_COUNT
);
  localparam int XW = ADDR_W - 2;
  localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  localparam logic [XW:0] NR = (XW+1)'(NUM_REGS);
  wr_state_t w_q;
  rd_state_t r_q;
  resp_t bresp_q, rresp_q;
  logic awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [31:0] wdata_q;
  logic [3:0] wstrb_q;
  logic [15:0] wr_count_q;
  logic aw_hs, w_hs, ar_hs, commit_d, wok_d, rok_d;
  logic [ADDR_W-1:0] waddr_d;
  logic [31:0] wdata_d;
  logic [3:0] wstrb_d;
  logic [XW-1:0] widx_d, ridx_d;
  logic unused_ok;
  assign aw_hs = s.awvalid & awready_q;
  assign w_hs = s.wvalid & wready_q;
  assign ar_hs = s.arvalid & arready_q;
  assign waddr_d = aw_hs ? s.awaddr : awaddr_q;
  assign wdata_d = w_hs ? s.wdata : wdata_q;
  assign wstrb_d = w_hs ? s.wstrb : wstrb_q;
  assign widx_d = waddr_d[ADDR_W-1:2];
  assign ridx_d = s.araddr[ADDR_W-1:2];
  assign wok_d = {1'b0, widx_d} < NR;
  assign rok_d = {1'b0, ridx_d} < NR;
  assign commit_d = (w_q == W_IDLE && aw_hs && w_hs) || (w_q == W_HAVE_A && w_hs) || (w_q == W_HAVE_D && aw_hs);
  // write FSM: collect AW and W in either order, commit on entry to W_RESP
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      w_q <= W_IDLE;
      {awready_q, wready_q, bvalid_q} <= '0;
      bresp_q <= RESP_OKAY;
      awaddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      wr_count_q <= '0;
    end else begin
      if (aw_hs) awaddr_q <= s.awaddr;
      if (w_hs) begin
        wdata_q <= s.wdata;
        wstrb_q <= s.wstrb;
      end
      if (commit_d) begin
        w_q <= W_RESP;
        {awready_q, wready_q, bvalid_q} <= 3'b001;
        bresp_q <= wok_d ? RESP_OKAY : RESP_SLVERR;
        if (wok_d) wr_count_q <= wr_count_q + 16'd1;
      end else if (w_q == W_IDLE && aw_hs) begin
        w_q <= W_HAVE_A;
        {awready_q, wready_q} <= 2'b01;
      end else if (w_q == W_IDLE && w_hs) begin
        w_q <= W_HAVE_D;
        {awready_q, wready_q} <= 2'b10;
      end else if (w_q == W_RESP && s.bready) begin
        w_q <= W_IDLE;
        {awready_q, wready_q, bvalid_q} <= 3'b110;
      end else if (w_q == W_IDLE) begin
        {awready_q, wready_q} <= 2'b11;
      end
    end
  // read FSM: one-cycle latency, response held until RREADY
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      r_q <= R_IDLE;
      {arready_q, rvalid_q} <= '0;
      rresp_q <= RESP_OKAY;
    end else if (r_q == R_IDLE && ar_hs) begin
      r_q <= R_RESP;
      {arready_q, rvalid_q} <= 2'b01;
      rresp_q <= rok_d ? RESP_OKAY : RESP_SLVERR;
    end else if (r_q == R_RESP && s.rready) begin
      r_q <= R_IDLE;
      {arready_q, rvalid_q} <= 2'b10;
    end else if (r_q == R_IDLE) begin
      arready_q <= 1'b1;
    end
  dcd_axil_regfile #(.NUM_REGS(NUM_REGS), .IW(IW)) u_regs (
    .clk(ACLK), .rst_n(ARESETN),
    .we_i(commit_d & wok_d), .widx_i(widx_d[IW-1:0]), .wdata_i(wdata_d), .wstrb_i(wstrb_d),
    .re_i(ar_hs), .rok_i(rok_d), .ridx_i(ridx_d[IW-1:0]), .rdata_o(s.rdata)
  );
  assign s.awready = awready_q;
  assign s.wready = wready_q;
  assign s.bvalid = bvalid_q;
  assign s.bresp = bresp_q;
  assign s.arready = arready_q;
  assign s.rvalid = rvalid_q;
  assign s.rresp = rresp_q;
  assign WR_COUNT = wr_count_q;
  assign unused_ok = ^{s.awprot, s.arprot, waddr_d[1:0], s.araddr[1:0]};
endmodule

// File: tb/tb_dcd_axil_sink_regs.sv
// tb_dcd_axil_sink_regs: directed checks of the AXI4-Lite sink register bank (NUM_REGS=8)
module tb_dcd_axil_sink_regs;
  logic clk = 1'b0;
  logic rst_n;
  logic [15:0] wr_count;
  int checks = 0;
  int failures = 0;
  dcd_axil_sink_regs_if #(.ADDR_W(6)) bus ();
  dcd_axil_sink_regs #(.ADDR_W(6), .NUM_REGS(8)) dut (
    .ACLK(clk), .ARESETN(rst_n), .s(bus.slave), .WR_COUNT(wr_count)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic wr(input string tag, input logic [5:0] a, input logic [31:0] d, input logic [3:0] st, input logic [1:0] er);
    bus.awaddr = a; bus.awvalid = 1'b1;
    bus.wdata = d; bus.wstrb = st; bus.wvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    chk({tag, "_bvalid"}, bus.bvalid, 1);
    chk({tag, "_bresp"}, bus.bresp, er);
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    chk({tag, "_bdone"}, bus.bvalid, 0);
    chk({tag, "_awready_b2b"}, bus.awready, 1);
  endtask
  task automatic rd(input string tag, input logic [5:0] a, input logic [31:0] ed, input logic [1:0] er);
    bus.araddr = a; bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    chk({tag, "_rvalid"}, bus.rvalid, 1);
    chk({tag, "_rdata"}, bus.rdata, ed);
    chk({tag, "_rresp"}, bus.rresp, er);
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    chk({tag, "_rdone"}, bus.rvalid, 0);
  endtask
  initial begin
    #200000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_n = 1'b0;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    repeat (3) tick();
    chk("rst_awready", bus.awready, 0);
    chk("rst_wready", bus.wready, 0);
    chk("rst_arready", bus.arready, 0);
    chk("rst_bvalid", bus.bvalid, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_wr_count", wr_count, 0);
    rst_n = 1'b1;
    chk("rel_awready_pre_edge", bus.awready, 0);
    tick();
    chk("rel_awready", bus.awready, 1);
    chk("rel_wready", bus.wready, 1);
    chk("rel_arready", bus.arready, 1);
    wr("t1_wr", 6'h04, 32'hDEADBEEF, 4'hF, 2'b00);
    chk("t1_count", wr_count, 1);
    rd("t1_rd", 6'h04, 32'hDEADBEEF, 2'b00);
    bus.wdata = 32'h12345678; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    chk("t2_wready_held0", bus.wready, 0);
    chk("t2_awready", bus.awready, 1);
    chk("t2_no_bvalid0", bus.bvalid, 0);
    tick();
    chk("t2_wready_held1", bus.wready, 0);
    chk("t2_no_bvalid1", bus.bvalid, 0);
    bus.awaddr = 6'h08; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    chk("t2_bvalid", bus.bvalid, 1);
    chk("t2_bresp", bus.bresp, 0);
    chk("t2_count", wr_count, 2);
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    rd("t2_rd", 6'h08, 32'h12345678, 2'b00);
    wr("t3_full", 6'h0C, 32'hFFFFFFFF, 4'hF, 2'b00);
    wr("t3_byte", 6'h0D, 32'h000000AA, 4'h1, 2'b00);
    rd("t3_rd", 6'h0C, 32'hFFFFFFAA, 2'b00);
    chk("t3_count", wr_count, 4);
    wr("t4_wr", 6'h3C, 32'h55555555, 4'hF, 2'b10);
    chk("t4_count", wr_count, 4);
    rd("t4_rd", 6'h3C, 32'h0, 2'b10);
    wr("strb0_wr", 6'h08, 32'hFFFFFFFF, 4'h0, 2'b00);
    chk("strb0_count", wr_count, 5);
    rd("strb0_rd", 6'h08, 32'h12345678, 2'b00);
    bus.awaddr = 6'h04; bus.awvalid = 1'b1;
    bus.wdata = 32'h11111111; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    bus.araddr = 6'h04; bus.arvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t5_bvalid", bus.bvalid, 1);
      chk("t5_bresp", bus.bresp, 0);
      chk("t5_rvalid", bus.rvalid, 1);
      chk("t5_rdata_old", bus.rdata, 32'hDEADBEEF);
      chk("t5_rresp", bus.rresp, 0);
      chk("t5_rdy", {bus.awready, bus.wready, bus.arready}, 0);
      tick();
    end
    bus.bready = 1'b1; bus.rready = 1'b1;
    tick();
    bus.bready = 1'b0; bus.rready = 1'b0;
    chk("t5_bdone", bus.bvalid, 0);
    chk("t5_rdone", bus.rvalid, 0);
    chk("t5_count", wr_count, 6);
    rd("t5_rd_new", 6'h04, 32'h11111111, 2'b00);
    bus.awaddr = 6'h14; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    chk("t6_have_a_awready", bus.awready, 0);
    chk("t6_have_a_wready", bus.wready, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_rdy", {bus.awready, bus.wready, bus.arready}, 0);
    chk("t6_rst_bvalid", bus.bvalid, 0);
    chk("t6_rst_count", wr_count, 0);
    chk("t6_rst_rdata", bus.rdata, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_no_bvalid", bus.bvalid, 0);
    chk("t6_rdy", {bus.awready, bus.wready, bus.arready}, 3'b111);
    rd("t6_rd_cleared", 6'h04, 32'h0, 2'b00);
    wr("t6_wr", 6'h14, 32'hCAFEF00D, 4'hF, 2'b00);
    chk("t6_count", wr_count, 1);
    rd("t6_rd", 6'h14, 32'hCAFEF00D, 2'b00);
    force dut.wr_count_q = 16'hFFFF;
    #1;
    release dut.wr_count_q;
    chk("wrap_pre", wr_count, 16'hFFFF);
    wr("wrap_wr", 6'h18, 32'h0BADF00D, 4'hF, 2'b00);
    chk("wrap_count", wr_count, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
